i2c_byte_engine: RTL
====================

# i2c_byte_engine

Byte-level I2C master engine that executes one bus instruction per request: START, STOP, READ_BYTE or WRITE_BYTE. It sits directly downstream of the ADC sequencer. That sequencer drives `instruction`, `enable` and `byteToSend`, and reads back `byteReceived` and `complete`. This block generates the SCL and SDA waveforms for the board-level open-drain pins.

## Interface
- `CLK_DIV`, default 67: clock cycles per quarter SCL bit (phase); must be ≥1. 67 gives ≈100 kHz SCL at 27 MHz.
- `clk` in 1: system clock; all state updates on rising edge.
- `reset` in 1: one clock; reset is asynchronous and active-high.
- `instruction` in 2: 0 = START, 1 = STOP, 2 = READ_BYTE, 3 = WRITE_BYTE; sampled at accept.
- `enable` in 1: request; level-held by the sequencer until `complete` is seen high.
- `byteToSend` in 8: WRITE_BYTE data, MSB first; sampled at accept.
- `ackRead` in 1: for READ_BYTE, 1 = master drives ACK (0), 0 = NACK (released); sampled at accept.
- `byteReceived` out 8: last READ_BYTE result.
- `ackReceived` out 1: SDA level sampled in the WRITE_BYTE ACK slot (0 = slave ACKed).
- `complete` out 1: instruction finished.
- `scl` out 1: SCL level.
- `sdaOut` out 1: SDA drive value.
- `isSending` out 1: 1 = drive `sdaOut` onto SDA, 0 = release (pull-up).
- `sdaIn` in 1: SDA pin level.

## Operation
- States: IDLE, RUN, DONE.
- Reset values: state IDLE, `scl`=1, `sdaOut`=1, `isSending`=0, `complete`=0, `byteReceived`=0, `ackReceived`=1, all counters 0.
- Accept: in IDLE with `enable`=1:
  - latch `instruction`, `byteToSend` and `ackRead`.
  - `complete`<=0; bit index 0, phase 0; go to RUN.
- Each bit has four phases (P0..P3), each lasting CLK_DIV cycles. The output values below are applied from the first cycle of each phase.
- START (1 bit, `isSending`=1): P0 scl0/sda1, P1 scl1/sda1, P2 scl1/sda0, P3 scl0/sda0. The same sequence serves as a repeated start.
- STOP (1 bit, `isSending`=1): P0 scl0/sda0, P1 scl1/sda0, P2 scl1/sda1, P3 scl1/sda1. The bus ends idle.
- Data bit (bits 0..7, MSB first):
  - Phase levels: P0 scl0, P1 scl1, P2 scl1, P3 scl0.
  - WRITE: `isSending`=1 and `sdaOut`=byte bit, set at P0.
  - READ: `isSending`=0; `sdaIn` is shifted in on the last cycle of P2.
- ACK bit (bit 8), same SCL pattern:
  - WRITE: released; `ackReceived`<=`sdaIn` on the last cycle of P2.
  - READ: `isSending`=`ackRead`, `sdaOut`=0.
- End of last phase:
  - READ only: `byteReceived`<=shift register.
  - `complete`<=1; go to DONE.
  - Pin outputs hold their last-phase values, so SCL stays low between bytes.
- DONE: when `enable`=0, go to IDLE with `complete` held at 1. No new instruction is accepted until `enable` has been seen low.
- `enable` dropped mid-RUN: ignored; the instruction runs to completion.
- Reset mid-RUN: immediate return to reset values. The bus is released with SCL high, and no STOP is issued.

## Timing
- Accept edge A: P0 outputs are visible after A.
- Phase k occupies cycles A+k·CLK_DIV .. A+(k+1)·CLK_DIV−1.
- `complete` rises at edge A+4·CLK_DIV for START/STOP and at A+36·CLK_DIV for READ/WRITE.
- `byteReceived` and `ackReceived` are valid in the same cycle that `complete` rises.
- Handshake: `complete` falls at the edge after accept, i.e. the first cycle the sequencer waits. The sequencer therefore sees `complete` low before it can see it high.
- Back-to-back requests: the minimum gap between instructions is 2 cycles (DONE→IDLE, then IDLE accept).

## Test plan
- START, CLK_DIV=2:
  - `enable` high → `complete`=0 one cycle after accept, `complete`=1 exactly 8 cycles after accept.
  - `scl` sequence 0,1,1,0 (2 cycles each); SDA falls only while `scl`=1.
- WRITE 0x91 with slave ACK (`sdaIn`=0 in the ACK slot):
  - SDA bits 1,0,0,1,0,0,0,1 are stable across every `scl` high phase.
  - `ackReceived`=0; `complete` at 72 cycles (CLK_DIV=2).
- READ with `sdaIn` pattern 0x85 and `ackRead`=1:
  - `byteReceived`=0x85 when `complete` rises.
  - `isSending`=1 and `sdaOut`=0 during the 9th bit.
- READ with `ackRead`=0 followed by STOP:
  - SDA released during the ACK slot; STOP ends with `scl`=1, `sdaOut`=1.
- `enable` held high after `complete`:
  - no second instruction starts; dropping `enable` returns to IDLE.
  - the next request is accepted 2 cycles later.
- `reset` asserted mid-WRITE bit 3:
  - outputs immediately become `scl`=1, `isSending`=0, `complete`=0.
  - a new START after release behaves exactly as in the START scenario.

Source files
------------

// File: rtl/i2c_byte_engine.sv
// Byte-level I2C master: runs one START, STOP, READ_BYTE or WRITE_BYTE per request.
// Each bus bit is four phases of CLK_DIV cycles; pin levels are registered per phase.
module i2c_byte_engine #(
  parameter int unsigned CLK_DIV = 67
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] instruction,
  input  logic       enable,
  input  logic [7:0] byteToSend,
  input  logic       ackRead,
  output logic [7:0] byteReceived,
  output logic       ackReceived,
  output logic       complete,
  output logic       scl,
  output logic       sdaOut,
  output logic       isSending,
  input  logic       sdaIn
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [1:0] InstrStart = 2'd0;
  localparam logic [1:0] InstrStop  = 2'd1;
  localparam logic [1:0] InstrRead  = 2'd2;
  localparam logic [1:0] InstrWrite = 2'd3;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [1:0]      instr_q, instr_d;
  logic [7:0]      tx_q, tx_d;
  logic            ack_read_q, ack_read_d;
  logic [3:0]      bit_q, bit_d;
  logic [1:0]      phase_q, phase_d;
  logic [DivW-1:0] div_q, div_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rx_q, rx_d;
  logic            ack_q, ack_d;
  logic            complete_q, complete_d;
  logic            scl_q, scl_d;
  logic            sda_q, sda_d;
  logic            send_q, send_d;
  logic [3:0]      last_bit;
  logic            div_end;

  // Returns {scl, sda, drive} for a given bit and phase of an instruction.
  function automatic logic [2:0] pin_levels(input logic [1:0] ins, input logic [7:0] tx,
                                            input logic ackr, input logic [3:0] bit_idx,
                                            input logic [1:0] ph);
    logic scl_l, sda_l, send_l;
    scl_l  = (ph == 2'd1) || (ph == 2'd2);
    sda_l  = 1'b1;
    send_l = 1'b0;
    unique case (ins)
      InstrStart: begin
        send_l = 1'b1;
        sda_l  = ~ph[1];
      end
      InstrStop: begin
        send_l = 1'b1;
        scl_l  = (ph != 2'd0);
        sda_l  = ph[1];
      end
      InstrRead: begin
        if (bit_idx == 4'd8) begin
          send_l = ackr;
          sda_l  = 1'b0;
        end
      end
      InstrWrite: begin
        if (bit_idx < 4'd8) begin
          send_l = 1'b1;
          sda_l  = tx[3'(4'd7 - bit_idx)];
        end
      end
    endcase
    return {scl_l, sda_l, send_l};
  endfunction

  assign last_bit = (instr_q == InstrRead || instr_q == InstrWrite) ? 4'd8 : 4'd0;
  assign div_end  = (div_q == DivW'(CLK_DIV - 1));

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    tx_d       = tx_q;
    ack_read_d = ack_read_q;
    bit_d      = bit_q;
    phase_d    = phase_q;
    div_d      = div_q;
    shift_d    = shift_q;
    rx_d       = rx_q;
    ack_d      = ack_q;
    complete_d = complete_q;
    scl_d      = scl_q;
    sda_d      = sda_q;
    send_d     = send_q;
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          instr_d    = instruction;
          tx_d       = byteToSend;
          ack_read_d = ackRead;
          complete_d = 1'b0;
          bit_d      = 4'd0;
          phase_d    = 2'd0;
          div_d      = '0;
          state_d    = StRun;
          {scl_d, sda_d, send_d} = pin_levels(instruction, byteToSend, ackRead, 4'd0, 2'd0);
        end
      end
      StRun: begin
        if (div_end) begin
          div_d = '0;
          // SDA is sampled on the last cycle of the SCL-high window.
          if (phase_q == 2'd2) begin
            if (instr_q == InstrRead && bit_q < 4'd8) shift_d = {shift_q[6:0], sdaIn};
            if (instr_q == InstrWrite && bit_q == 4'd8) ack_d = sdaIn;
          end
          if (phase_q == 2'd3) begin
            if (bit_q == last_bit) begin
              if (instr_q == InstrRead) rx_d = shift_q;
              complete_d = 1'b1;
              state_d    = StDone;
            end else begin
              bit_d   = bit_q + 4'd1;
              phase_d = 2'd0;
              {scl_d, sda_d, send_d} = pin_levels(instr_q, tx_q, ack_read_q, bit_q + 4'd1, 2'd0);
            end
          end else begin
            phase_d = phase_q + 2'd1;
            {scl_d, sda_d, send_d} = pin_levels(instr_q, tx_q, ack_read_q, bit_q, phase_q + 2'd1);
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StDone: begin
        if (!enable) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      instr_q    <= 2'd0;
      tx_q       <= 8'd0;
      ack_read_q <= 1'b0;
      bit_q      <= 4'd0;
      phase_q    <= 2'd0;
      div_q      <= '0;
      shift_q    <= 8'd0;
      rx_q       <= 8'd0;
      ack_q      <= 1'b1;
      complete_q <= 1'b0;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      send_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      tx_q       <= tx_d;
      ack_read_q <= ack_read_d;
      bit_q      <= bit_d;
      phase_q    <= phase_d;
      div_q      <= div_d;
      shift_q    <= shift_d;
      rx_q       <= rx_d;
      ack_q      <= ack_d;
      complete_q <= complete_d;
      scl_q      <= scl_d;
      sda_q      <= sda_d;
      send_q     <= send_d;
    end
  end

  assign byteReceived = rx_q;
  assign ackReceived  = ack_q;
  assign complete     = complete_q;
  assign scl          = scl_q;
  assign sdaOut       = sda_q;
  assign isSending    = send_q;

endmodule
